// File: rtl/add_sub_pkg.sv
// Shared types and helpers for the chunked adder/subtractor.
package add_sub_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } as_state_t;

  function automatic int nchunk(input int width, input int chunk);
    return (width + chunk - 1) / chunk;
  endfunction

endpackage

// File: rtl/add_sub_chunked_chunk_adder.sv
// CHUNK-bit ripple of full_adder cells; also exposes the carry into the top bit.
module chunk_adder #(
  parameter int CHUNK = 3
) (
  input  logic             cin,
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b,
  output logic [CHUNK-1:0] s,
  output logic             cout,
  output logic             msb_carry_in
);

  logic [CHUNK:0] w_c;

  assign w_c[0] = cin;

  for (genvar i = 0; i < CHUNK; i++) begin : g_bit
    full_adder u_fa (
      .a   (a[i]),
      .b   (b[i]),
      .cin (w_c[i]),
      .s   (s[i]),
      .cout(w_c[i+1])
    );
  end

  assign cout         = w_c[CHUNK];
  assign msb_carry_in = w_c[CHUNK-1];

endmodule

// File: rtl/full_adder.sv
// Single-bit full adder cell used to build the chunk ripple.
module full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);

  assign s    = a ^ b ^ cin;
  assign cout = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/add_sub_chunked.sv
// Multi-cycle two's-complement adder/subtractor, CHUNK bits per clock with a
// registered carry between chunks and a Start/Done handshake.
module add_sub_chunked
  import add_sub_pkg::*;
#(
  parameter int WIDTH = 9,
  parameter int CHUNK = 3
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Start,
  input  logic             Sub,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic [WIDTH-1:0] S,
  output logic             Cout,
  output logic             Ovf,
  output logic             Busy,
  output logic             Done
);

  localparam int NCHUNK = nchunk(WIDTH, CHUNK);
  localparam int EXT    = NCHUNK * CHUNK;
  localparam int PAD    = EXT - WIDTH;
  localparam int LO     = (NCHUNK - 1) * CHUNK;
  localparam int IDX_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NCHUNK - 1);

  as_state_t        r_state;
  logic [IDX_W-1:0] r_idx;
  logic             r_carry;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [EXT-1:0]   r_sum;
  logic [WIDTH-1:0] r_s;
  logic             r_cout;
  logic             r_ovf;
  logic             r_busy;
  logic             r_done;

  logic [EXT-1:0]   w_a_ext;
  logic [EXT-1:0]   w_b_ext;
  logic [31:0]      w_base;
  logic [CHUNK-1:0] w_a_chunk;
  logic [CHUNK-1:0] w_b_chunk;
  logic [CHUNK-1:0] w_s_chunk;
  logic             w_cout;
  logic             w_msb_cin;
  logic [EXT-1:0]   w_sum_full;
  logic [WIDTH-1:0] w_s_final;
  logic             w_accept;

  // A partial last chunk is padded *below* its real bits with a=1, b=0: the
  // carry passes through the pad unchanged, so the chunk MSB is the true MSB
  // and cout / msb_carry_in are the real final carries.
  if (PAD == 0) begin : g_nopad
    assign w_a_ext   = r_a;
    assign w_b_ext   = r_b;
    assign w_s_final = w_sum_full;
  end else begin : g_pad
    assign w_a_ext   = {r_a[WIDTH-1:LO], {PAD{1'b1}}, r_a[LO-1:0]};
    assign w_b_ext   = {r_b[WIDTH-1:LO], {PAD{1'b0}}, r_b[LO-1:0]};
    assign w_s_final = {w_sum_full[EXT-1:LO+PAD], w_sum_full[LO-1:0]};
  end

  assign w_base    = 32'(r_idx) * 32'(CHUNK);
  assign w_a_chunk = w_a_ext[w_base +: CHUNK];
  assign w_b_chunk = w_b_ext[w_base +: CHUNK];

  chunk_adder #(.CHUNK(CHUNK)) u_chunk (
    .cin         (r_carry),
    .a           (w_a_chunk),
    .b           (w_b_chunk),
    .s           (w_s_chunk),
    .cout        (w_cout),
    .msb_carry_in(w_msb_cin)
  );

  always_comb begin
    w_sum_full = r_sum;
    w_sum_full[w_base +: CHUNK] = w_s_chunk;
  end

  assign w_accept = Start && (r_state == IDLE || r_state == DONE);

  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_state <= IDLE;
      r_idx   <= '0;
      r_carry <= 1'b0;
      r_a     <= '0;
      r_b     <= '0;
      r_sum   <= '0;
      r_s     <= '0;
      r_cout  <= 1'b0;
      r_ovf   <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (w_accept) begin
        // Subtraction is A + ~B + 1: invert B here, seed the carry with Sub.
        r_state <= RUN;
        r_busy  <= 1'b1;
        r_idx   <= '0;
        r_a     <= A;
        r_b     <= Sub ? ~B : B;
        r_carry <= Sub;
      end else begin
        case (r_state)
          RUN: begin
            r_sum   <= w_sum_full;
            r_carry <= w_cout;
            if (r_idx == LAST_IDX) begin
              r_state <= DONE;
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
              r_idx   <= '0;
              r_s     <= w_s_final;
              r_cout  <= w_cout;
              r_ovf   <= w_cout ^ w_msb_cin;
            end else begin
              r_idx <= r_idx + 1'b1;
            end
          end
          DONE:    r_state <= IDLE;
          default: r_state <= IDLE;
        endcase
      end
    end
  end

  assign S    = r_s;
  assign Cout = r_cout;
  assign Ovf  = r_ovf;
  assign Busy = r_busy;
  assign Done = r_done;

endmodule

// File: tb/tb_add_sub_chunked.sv
// Directed bench for add_sub_chunked: 9-bit/3-bit instance plus an 8-bit one
// exercising the partial last chunk.
module tb_add_sub_chunked;

  logic       Clk = 1'b0;
  logic       Reset;
  logic       Start9, Sub9, Start8, Sub8;
  logic [8:0] A9, B9, S9;
  logic [7:0] A8, B8, S8;
  logic       Cout9, Ovf9, Busy9, Done9;
  logic       Cout8, Ovf8, Busy8, Done8;

  int passed = 0;
  int total  = 0;
  int ndone;

  always #5 Clk = ~Clk;

  add_sub_chunked dut9 (
    .Clk(Clk), .Reset(Reset), .Start(Start9), .Sub(Sub9), .A(A9), .B(B9),
    .S(S9), .Cout(Cout9), .Ovf(Ovf9), .Busy(Busy9), .Done(Done9)
  );

  add_sub_chunked #(.WIDTH(8), .CHUNK(3)) dut8 (
    .Clk(Clk), .Reset(Reset), .Start(Start8), .Sub(Sub8), .A(A8), .B(B8),
    .S(S8), .Cout(Cout8), .Ovf(Ovf8), .Busy(Busy8), .Done(Done8)
  );

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: got %h expected %h", tag, obs, exp);
  endtask

  // Start at edge t; checks Busy over t+1..t+3 and Done/results at t+4.
  task automatic op9(input string tag, input logic sub, input logic [8:0] a, input logic [8:0] b,
                     input logic [8:0] es, input logic ec, input logic ev);
    Start9 = 1'b1; Sub9 = sub; A9 = a; B9 = b;
    tick();
    Start9 = 1'b0; A9 = '0; B9 = '0; Sub9 = 1'b0;
    chk({tag, " busy t+1"}, 16'(Busy9), 16'd1);
    tick();
    chk({tag, " busy t+2"}, 16'(Busy9), 16'd1);
    tick();
    chk({tag, " busy t+3"}, 16'(Busy9), 16'd1);
    chk({tag, " done t+3"}, 16'(Done9), 16'd0);
    tick();
    chk({tag, " done t+4"}, 16'(Done9), 16'd1);
    chk({tag, " busy t+4"}, 16'(Busy9), 16'd0);
    chk({tag, " S"}, 16'(S9), 16'(es));
    chk({tag, " Cout"}, 16'(Cout9), 16'(ec));
    chk({tag, " Ovf"}, 16'(Ovf9), 16'(ev));
    tick();
    chk({tag, " done t+5"}, 16'(Done9), 16'd0);
  endtask

  task automatic op8(input string tag, input logic [7:0] a, input logic [7:0] b,
                     input logic [7:0] es, input logic ec, input logic ev);
    Start8 = 1'b1; Sub8 = 1'b0; A8 = a; B8 = b;
    tick();
    Start8 = 1'b0; A8 = '0; B8 = '0;
    chk({tag, " busy t+1"}, 16'(Busy8), 16'd1);
    tick();
    tick();
    chk({tag, " done t+3"}, 16'(Done8), 16'd0);
    tick();
    chk({tag, " done t+4"}, 16'(Done8), 16'd1);
    chk({tag, " S"}, 16'(S8), 16'(es));
    chk({tag, " Cout"}, 16'(Cout8), 16'(ec));
    chk({tag, " Ovf"}, 16'(Ovf8), 16'(ev));
    tick();
  endtask

  initial begin
    Reset = 1'b1;
    Start9 = 1'b0; Sub9 = 1'b0; A9 = '0; B9 = '0;
    Start8 = 1'b0; Sub8 = 1'b0; A8 = '0; B8 = '0;
    tick();
    tick();
    chk("rst S9", 16'(S9), 16'h0);
    chk("rst Cout9", 16'(Cout9), 16'h0);
    chk("rst Ovf9", 16'(Ovf9), 16'h0);
    chk("rst Busy9", 16'(Busy9), 16'h0);
    chk("rst Done9", 16'(Done9), 16'h0);
    chk("rst Busy8", 16'(Busy8), 16'h0);
    Reset = 1'b0;
    tick();

    op9("carry", 1'b0, 9'h007, 9'h001, 9'h008, 1'b0, 1'b0);
    op9("wrap",  1'b0, 9'h1FF, 9'h001, 9'h000, 1'b1, 1'b0);
    op9("ovf",   1'b0, 9'h0FF, 9'h001, 9'h100, 1'b0, 1'b1);
    op9("borrow", 1'b1, 9'h005, 9'h007, 9'h1FE, 1'b0, 1'b0);
    op9("noborrow", 1'b1, 9'h007, 9'h005, 9'h002, 1'b1, 1'b0);

    // Ignored Start during RUN, then back-to-back from the DONE cycle.
    Start9 = 1'b1; A9 = 9'h010; B9 = 9'h020;
    tick();                                   // cycle t+1
    Start9 = 1'b0;
    chk("ign S held", 16'(S9), 16'h002);
    tick();                                   // cycle t+2, Start sampled at edge t+2
    Start9 = 1'b1; A9 = 9'h100; B9 = 9'h100;
    tick();                                   // cycle t+3
    Start9 = 1'b0;
    chk("ign done t+3", 16'(Done9), 16'd0);
    chk("ign busy t+3", 16'(Busy9), 16'd1);
    tick();                                   // cycle t+4
    chk("ign done t+4", 16'(Done9), 16'd1);
    chk("ign S", 16'(S9), 16'h030);
    Start9 = 1'b1; A9 = 9'h003; B9 = 9'h004;
    tick();                                   // cycle t+5 = t'+1
    Start9 = 1'b0; A9 = '0; B9 = '0;
    chk("b2b busy", 16'(Busy9), 16'd1);
    chk("b2b done low", 16'(Done9), 16'd0);
    chk("b2b S held", 16'(S9), 16'h030);
    tick();
    tick();
    chk("b2b done t'+3", 16'(Done9), 16'd0);
    tick();
    chk("b2b done t'+4", 16'(Done9), 16'd1);
    chk("b2b S", 16'(S9), 16'h007);
    tick();
    chk("b2b done t'+5", 16'(Done9), 16'd0);

    // Reset at edge t+2 aborts the operation.
    Start9 = 1'b1; A9 = 9'h055; B9 = 9'h011;
    tick();
    Start9 = 1'b0;
    chk("abort busy t+1", 16'(Busy9), 16'd1);
    tick();
    Reset = 1'b1;
    tick();
    Reset = 1'b0;
    chk("abort busy", 16'(Busy9), 16'd0);
    chk("abort S", 16'(S9), 16'h000);
    chk("abort Cout", 16'(Cout9), 16'h0);
    chk("abort Ovf", 16'(Ovf9), 16'h0);
    ndone = 0;
    for (int i = 0; i < 6; i++) begin
      if (Done9) ndone++;
      tick();
    end
    chk("abort no done", 16'(ndone), 16'd0);

    // Reset and Start in the same cycle: Start dropped.
    Reset = 1'b1; Start9 = 1'b1; A9 = 9'h001; B9 = 9'h001;
    tick();
    Reset = 1'b0; Start9 = 1'b0;
    chk("rst+start busy", 16'(Busy9), 16'd0);
    tick();
    chk("rst+start busy2", 16'(Busy9), 16'd0);
    chk("rst+start done", 16'(Done9), 16'd0);

    op8("w8 wrap", 8'hFF, 8'h01, 8'h00, 1'b1, 1'b0);
    op8("w8 ovf",  8'h7F, 8'h01, 8'h80, 1'b0, 1'b1);
    op8("w8 mix",  8'h3C, 8'h47, 8'h83, 1'b0, 1'b1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/add_sub_chunked.md
# add_sub_chunked

Parametrised multi-cycle two's-complement adder/subtractor. It processes `CHUNK` bits per clock and keeps the carry in a register between chunks, so operand width grows without lengthening the ripple path. It replaces the fixed 9-bit combinational adder in the lab datapath (add-shift multiplier, switch accumulator). It adds subtract mode, carry and overflow flags, and a Start/Done handshake.

## Interface
- `WIDTH`, default 9: operand and result width; must be ≥ 2.
- `CHUNK`, default 3: bits added per cycle, 1 ≤ `CHUNK` ≤ `WIDTH`. `NCHUNK` = ceil(`WIDTH`/`CHUNK`).
- `Clk`  in  1: sole clock, rising edge.
- `Reset`  in  1: synchronous, active-high.
- `Start`  in  1: request a new operation; sampled on `Clk`.
- `Sub`  in  1: 0 computes A+B; 1 computes A−B. Captured with `Start`.
- `A`  in  `WIDTH`: operand A, captured on `Start` acceptance.
- `B`  in  `WIDTH`: operand B, captured on `Start` acceptance.
- `S`  out  `WIDTH`: result; holds until the next completion.
- `Cout`  out  1: carry out of the MSB. In subtract mode, 1 means no borrow.
- `Ovf`  out  1: signed overflow.
- `Busy`  out  1: high while chunks are being processed.
- `Done`  out  1: one-cycle pulse when `S`, `Cout` and `Ovf` become valid.

## Operation
- Operation: `S` = A + (`Sub` ? ~B : B) + `Sub`, modulo 2^`WIDTH`. `Cout` is the final carry.
- `Ovf` = (A[msb] == Beff[msb]) && (S[msb] != A[msb]), where Beff is B after conditional inversion.
- States:
  - IDLE: `Busy`=0, `Done`=0.
  - RUN: `Busy`=1. Chunk index counter runs 0..`NCHUNK`−1.
  - DONE: `Done`=1 for exactly one cycle.
- Transitions:
  - IDLE→RUN on `Start`.
  - RUN→RUN while index < `NCHUNK`−1.
  - RUN→DONE after the last chunk.
  - DONE→RUN if `Start` is high, otherwise DONE→IDLE.
- Acceptance: `Start` is accepted only in IDLE or DONE. `Start` during RUN is ignored, with no queuing. Operands are captured into internal registers on acceptance; later changes on A/B/`Sub` have no effect.
- Chunk k adds bits [k·CHUNK +: CHUNK] with carry-in from the registered carry. The carry-in for chunk 0 is `Sub`.
- Partial last chunk: it is `WIDTH` − (`NCHUNK`−1)·`CHUNK` bits wide. The carry is taken at the true MSB, not at the chunk boundary.
- Partial sums go to an internal register. `S`, `Cout` and `Ovf` update only on entry to DONE and stay visible while in RUN of a later operation.
- Reset values: state IDLE, index 0, `S`=0, `Cout`=0, `Ovf`=0, `Busy`=0, `Done`=0, internal operands 0.
- Reset mid-operation aborts it: no `Done`, and outputs are cleared to reset values on the next edge.
- Reset and `Start` in the same cycle: Reset wins and `Start` is dropped.

## Timing
- `Start` sampled high at edge t:
  - RUN occupies cycles t+1 … t+`NCHUNK`.
  - `Done`=1 and outputs valid in cycle t+`NCHUNK`+1.
- Latency from `Start` edge to `Done` is `NCHUNK`+1 cycles. For the defaults that is 4.
- Back-to-back operation: `Start` held high in the DONE cycle gives throughput of one result every `NCHUNK`+1 cycles.
- `Busy` and `Done` are registered state decodes with no combinational path from inputs.
- Critical path is one `CHUNK`-bit ripple plus the carry mux, independent of `WIDTH`.

## Structure
- Package `add_sub_pkg` holds:
  - the state enum `as_state_t` {IDLE, RUN, DONE};
  - the function `nchunk(WIDTH, CHUNK)` computing ceil division.
- Sub-module `chunk_adder`: a `CHUNK`-bit ripple of the existing `full_adder` cells. It has cin, a, b, s and cout outputs, plus `msb_carry_in`, which is needed for the overflow term. It is instantiated once. The top level does the operand slicing with a variable-index part-select and masks the partial last chunk.
- The top level contains the FSM, chunk counter, carry register, operand registers and result registers.

## Test plan
All scenarios use `WIDTH`=9, `CHUNK`=3 unless stated otherwise.
- **Cross-chunk carry:** 9'h007 + 9'h001 → `S`=9'h008, `Cout`=0, `Ovf`=0, `Done` in cycle t+4 only. `Busy` high in t+1..t+3.
- **Wrap-around:** 9'h1FF + 9'h001 → `S`=9'h000, `Cout`=1, `Ovf`=0. Overflow case: 9'h0FF + 9'h001 → `S`=9'h100, `Cout`=0, `Ovf`=1.
- **Subtract with borrow:** `Sub`=1, 9'h005 − 9'h007 → `S`=9'h1FE, `Cout`=0, `Ovf`=0. Without borrow: 9'h007 − 9'h005 → `S`=9'h002, `Cout`=1.
- **Ignored Start and back-to-back:** `Start` pulsed at t+2 with different A is ignored, and the result matches the first operation. `Start` held high in the DONE cycle runs a second operation whose `Done` appears 4 cycles later.
- **Reset mid-operation:** `Reset` at t+2 → next cycle `Busy`=0, `S`=0, `Cout`=0, `Ovf`=0, and no `Done` pulse follows.
- **Partial chunk:** `WIDTH`=8, `CHUNK`=3, 8'hFF + 8'h01 → `S`=8'h00, `Cout`=1, `Ovf`=0, `Done` at t+4.
